// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Byte-wide memory responder for the multicycle MIPS controller/datapath.
// A read returns a little-endian 32-bit word that is assembled one byte lane
// per cycle over four cycles. A write stores a single byte. Either kind of
// request finishes with a one-cycle memready pulse.
//
// Optional feature (compile-time macro): MEMRESP_LOAD_EN
//   Defined   : load_we/load_adr/load_data preload storage in any state.
//               In IDLE a preload takes priority over a pending request.
//   Undefined : the preload port is ignored.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   adr        in   byte address of the request
//   writedata  in   byte to store on memwrite
//   memread    in   read request, held by the initiator until memready
//   memwrite   in   write request, held by the initiator until memready
//   readdata   out  assembled word, byte at adr in [7:0]
//   memready   out  one-cycle completion pulse
//   busy       out  high whenever the FSM is not in IDLE
//   err        out  sticky flag: memread and memwrite requested together
//   load_we    in   preload byte write enable
//   load_adr   in   preload address
//   load_data  in   preload byte
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [7:0]        writedata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [31:0]       readdata,
    output logic              memready,
    output logic              busy,
    output logic              err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_adr,
    input  logic [7:0]        load_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] radr_q;
    logic [1:0]        cnt_q;
    logic [31:0]       readdata_q;
    logic              memready_q;
    logic              busy_q;
    logic              err_q;

    logic [7:0]        mem [0:(2**ADDR_W)-1];

    logic              load_active;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_byte;
    logic              write_accept;

`ifdef MEMRESP_LOAD_EN
    assign load_active = load_we;
`else
    assign load_active = 1'b0;
    // Preload port exists for pin compatibility only in this build.
    logic unused_load;
    assign unused_load = ^{load_we, load_adr, load_data};
`endif

    // Lane address wraps naturally at the storage depth.
    assign rd_addr      = radr_q + ADDR_W'(cnt_q);
    assign rd_byte      = mem[rd_addr];
    assign write_accept = (state_q == IDLE) && !load_active && memwrite;

    // NOTE: storage has no reset branch; only the control registers are reset,
    // which keeps the array mappable onto plain RAM. Writes are suppressed
    // while reset is high so an aborted cycle never touches storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef MEMRESP_LOAD_EN
            if (load_we) begin
                mem[load_adr] <= load_data;
            end
`endif
            if (write_accept) begin
                mem[adr] <= writedata;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers, whatever the order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            radr_q     <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
            memready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            memready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A preload owns this edge; the request waits in IDLE.
                    if (!load_active) begin
                        if (memwrite) begin
                            state_q    <= DONE;
                            memready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            if (memread) begin
                                err_q <= 1'b1;
                            end
                        end else if (memread) begin
                            radr_q  <= adr;
                            cnt_q   <= '0;
                            state_q <= RD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    readdata_q[{cnt_q, 3'b000} +: 8] <= rd_byte;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q    <= DONE;
                        memready_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Requests still asserted here are picked up from IDLE.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign readdata = readdata_q;
    assign memready = memready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. A table of write/read operations is
// applied in a loop, followed by hand-written sequences for the multi-cycle
// corner cases: simultaneous read/write, requests while busy, reset in the
// middle of a read and (with MEMRESP_LOAD_EN) preload priority.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] adr;
    logic [7:0]        writedata;
    logic              memread;
    logic              memwrite;
    logic [31:0]       readdata;
    logic              memready;
    logic              busy;
    logic              err;
    logic              load_we;
    logic [ADDR_W-1:0] load_adr;
    logic [7:0]        load_data;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memread   (memread),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .memready  (memready),
        .busy      (busy),
        .err       (err),
        .load_we   (load_we),
        .load_adr  (load_adr),
        .load_data (load_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Counts falling edges after the accepting rising edge until memready.
    // Returns 0 if the pulse never arrives within the budget.
    task automatic wait_ready(input logic chk_busy, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (chk_busy && i == 2) check("busy_during_rd", {31'd0, busy}, 32'd1);
            if (memready) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge in IDLE.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int lat);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        wait_ready(1'b0, lat);
        memwrite  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] data, output int lat);
        adr     = a;
        memread = 1'b1;
        @(posedge clk);
        #1;
        adr = ~a;              // address changes during RD must be ignored
        wait_ready(1'b1, lat);
        memread = 1'b0;
        data    = readdata;
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        int          lat;
        logic [31:0] data;
        logic [31:0] prev;
        bit          seen;

        vecs[0]  = '{1'b1, 8'h10, 8'h8C, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 8'h11, 8'hA2, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 8'h12, 8'h00, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 8'h13, 8'h04, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 8'h10, 8'h00, 32'h0400A28C, 32'hFFFFFFFF};
        vecs[5]  = '{1'b1, 8'h20, 8'h5A, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 8'h20, 8'h00, 32'h0000005A, 32'h000000FF};
        vecs[7]  = '{1'b1, 8'hFE, 8'h11, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 8'hFF, 8'h22, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 8'h00, 8'h33, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 8'h01, 8'h44, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 8'hFE, 8'h00, 32'h44332211, 32'hFFFFFFFF};
        vecs[12] = '{1'b1, 8'h11, 8'hEE, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 8'h10, 8'h00, 32'h0400EE8C, 32'hFFFFFFFF};
        vecs[14] = '{1'b0, 8'h12, 8'h00, 32'h00000400, 32'h0000FFFF};

        reset     = 1'b1;
        adr       = '0;
        writedata = '0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        load_we   = 1'b0;
        load_adr  = '0;
        load_data = '0;
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_memready", {31'd0, memready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                prev = readdata;
                do_write(vecs[i].a, vecs[i].d, lat);
                check($sformatf("wr%0d_latency", i), lat, 32'd1);
                check($sformatf("wr%0d_readdata_kept", i), readdata, prev);
            end else begin
                do_read(vecs[i].a, data, lat);
                check($sformatf("rd%0d_latency", i), lat, 32'd5);
                check($sformatf("rd%0d_data", i), data & vecs[i].mask, vecs[i].exp);
            end
            check($sformatf("op%0d_idle_after", i), {31'd0, busy}, 32'd0);
        end

        // ---------------- memread and memwrite together ----------------
        prev      = readdata;
        adr       = 8'h30;
        writedata = 8'h77;
        memread   = 1'b1;
        memwrite  = 1'b1;
        @(negedge clk);
        check("both_memready", {31'd0, memready}, 32'd1);
        check("both_err", {31'd0, err}, 32'd1);
        memread  = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);
        check("both_single_pulse", {31'd0, memready}, 32'd0);
        check("both_readdata_kept", readdata, prev);
        do_read(8'h30, data, lat);
        check("both_stored_byte", data & 32'hFF, 32'h77);
        check("err_sticky", {31'd0, err}, 32'd1);

        // ---------------- requests while busy are ignored ----------------
        adr     = 8'h10;
        memread = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b1;
        writedata = 8'h55;
        repeat (3) @(negedge clk);
        memwrite = 1'b0;
        wait_ready(1'b0, lat);
        memread = 1'b0;
        check("busy_req_latency", lat, 32'd2);
        check("busy_req_data", readdata, 32'h0400EE8C);
        @(negedge clk);
        do_read(8'h10, data, lat);
        check("busy_write_dropped", data, 32'h0400EE8C);

        // ---------------- reset during the second RD cycle ----------------
        adr     = 8'h20;
        memread = 1'b1;
        @(posedge clk);          // accepted
        @(posedge clk);          // lane 0 loaded
        @(negedge clk);
        reset   = 1'b1;
        memread = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (memready) seen = 1'b1;
        end
        check("mid_rst_no_pulse", {31'd0, seen}, 32'd0);
        do_read(8'h10, data, lat);
        check("post_rst_latency", lat, 32'd5);
        check("post_rst_data", data, 32'h0400EE8C);

`ifdef MEMRESP_LOAD_EN
        // ---------------- preload has priority over a read in IDLE ----------------
        load_we   = 1'b1;
        load_adr  = 8'h50;
        load_data = 8'hC3;
        adr       = 8'h50;
        memread   = 1'b1;
        @(negedge clk);
        check("load_prio_not_busy", {31'd0, busy}, 32'd0);
        load_we = 1'b0;
        wait_ready(1'b1, lat);
        memread = 1'b0;
        check("load_read_latency", lat, 32'd5);
        check("load_read_data", readdata & 32'hFF, 32'hC3);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory responder for the multicycle MIPS controller/datapath. It sits at the far end of the memread/memwrite/address interface that the controller drives.
- Backed by a byte-wide storage array.
- Returns a 32-bit little-endian word for instruction fetch and LB, assembled over four cycles.
- Performs single-byte stores for SB.
- Signals completion with a one-cycle memready pulse, which the datapath uses to hold its state.

Parameters:
ADDR_W, 8, byte-address width; storage depth is 2**ADDR_W bytes.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
adr  input  ADDR_W  byte address (PC or ALU result selected by iord)
writedata  input  8  store byte for SB
memread  input  1  read request; held by the initiator until memready
memwrite  input  1  write request; held by the initiator until memready
readdata  output  32  assembled word; byte at adr appears in [7:0]
memready  output  1  one-cycle completion pulse
busy  output  1  high whenever state is not IDLE
err  output  1  sticky protocol-error flag
load_we  input  1  preload byte write (see Optional Feature)
load_adr  input  ADDR_W  preload address
load_data  input  8  preload byte

Behaviour:
- Reset: clk and reset as already decided (reset synchronous, active-high; clock clk).
  - Reset values: state=IDLE, readdata=0, memready=0, busy=0, err=0, byte counter=0, latched address=0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the operation. A partially assembled readdata is zeroed. No further lanes are written and no memready pulse is produced.
- FSM states: IDLE, RD, DONE.
- IDLE transitions:
  - memwrite=1: at this edge, mem[adr] <= writedata. Go to DONE.
  - memread=1 and memwrite=0: latch adr into radr, cnt <= 0, go to RD.
  - memread=1 and memwrite=1: write wins (as above), read is dropped, err <= 1.
- RD transitions:
  - Each edge: readdata[8*cnt+7 : 8*cnt] <= mem[(radr+cnt) mod 2**ADDR_W], then cnt <= cnt+1.
  - After lane 3 is loaded, go to DONE. Address wraps modulo depth; e.g. radr=0xFE reads bytes 0xFE, 0xFF, 0x00, 0x01.
- DONE: memready=1 for exactly this cycle, then go to IDLE.
- Latency:
  - Read: request sampled at edge E0; lanes 0..3 loaded at E1..E4; memready high in the cycle after E4.
  - Write: request sampled at E0; memready high in the cycle after E0.
- readdata holds its value between reads. Writes never modify readdata.
- memread/memwrite while busy=1 are ignored; changes to adr during RD have no effect.
- A request still asserted in the DONE cycle is not accepted there. It is accepted from IDLE on the next edge; the initiator must drop the request on memready.
- Back-to-back throughput: read every 6 cycles, write every 2 cycles.
- Read-after-write to the same address returns the new byte.
- err is cleared only by reset.

Optional Feature:
MEMRESP_LOAD_EN
- Defined: load_we=1 writes mem[load_adr] <= load_data at the edge, in any state.
  - In IDLE, a load takes priority: a pending memread/memwrite is not accepted that cycle and is accepted on the first later IDLE edge with load_we=0.
  - A load landing on an address not yet read by an in-flight RD is visible to that read.
- Undefined: load_we/load_adr/load_data are ignored; storage is written only via memwrite.

Test Plan:
- Reset, preload (MEMRESP_LOAD_EN) bytes 0x10..0x13 = 8C,A2,00,04 -> memread, adr=0x10 -> memready in 5th cycle after acceptance, readdata=0x0400A28C, busy=1 during RD.
- memwrite adr=0x20 writedata=0x5A -> memready next cycle; then memread adr=0x20 -> readdata[7:0]=0x5A.
- Preload 0xFE,0xFF,0x00,0x01 = 11,22,33,44; memread adr=0xFE (ADDR_W=8) -> readdata=0x44332211.
- memread and memwrite together in IDLE, adr=0x30, writedata=0x77 -> mem[0x30]=0x77, err=1 and stays 1, readdata unchanged, single memready.
- Reset asserted during the 2nd RD cycle -> next cycle state IDLE, readdata=0, no memready pulse, err=0; subsequent read completes normally.
- With MEMRESP_LOAD_EN, load_we and memread both asserted in IDLE -> read accepted only after load_we drops; readdata reflects the loaded byte.
